uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame, LSB first.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per bit period; legal range 4..65535.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_en  input  1  receiver enable; low forces FSM to IDLE.
REQ-006 ftdi_rx  input  1  serial line from FTDI, asynchronous to clk, idle high.
REQ-007 rx_byte  output  DATA_WIDTH  received data, valid while rx_valid=1.
REQ-008 rx_valid  output  1  output buffer holds an unconsumed byte.
REQ-009 rx_ready  input  1  consumer accepts; transfer when rx_valid & rx_ready in the same cycle.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 overrun  output  1  one-cycle pulse: frame completed while buffer full and not draining.
REQ-012 parity_err  output  1  one-cycle pulse: parity mismatch (see Configuration).

Function
REQ-013 ftdi_rx SHALL pass through a 2-flop synchronizer (sync flops reset to 1); all decoding uses the synchronized value.
REQ-014 FSM states: IDLE, START, DATA, PARITY (only when compiled in), STOP.
REQ-015 IDLE -> START on a synchronized high-to-low transition while rx_en=1; the bit counter is cleared.
REQ-016 START: sample at count CLKS_PER_BIT/2 (integer division); if low -> DATA with counter restarted; if high -> IDLE (false start, no flags).
REQ-017 DATA: sample every CLKS_PER_BIT cycles thereafter; shift into bit position 0..DATA_WIDTH-1 in order; after the last bit -> PARITY or STOP.
REQ-018 STOP: sample one bit period after the last sample; high -> frame good; low -> frame_err pulse, byte discarded.
REQ-019 After a frame error the FSM SHALL remain in STOP until the synchronized line is high, then go to IDLE; no new start is detected while the line stays low.
REQ-020 A good frame SHALL load rx_byte and set rx_valid on the cycle after the stop sample.
REQ-021 rx_valid SHALL clear on the cycle after a handshake; rx_byte holds its value until the next load.
REQ-022 A good frame completing while rx_valid=1 and rx_ready=0 SHALL pulse overrun, drop the new byte, and keep the old byte.
REQ-023 A good frame completing in the same cycle as a handshake SHALL load the new byte, keep rx_valid=1, and raise no overrun.
REQ-024 A good frame with a parity error SHALL pulse parity_err and still be loaded.
REQ-025 rx_en deassert mid-frame SHALL abandon the frame (IDLE next cycle, no flags, no load); buffer contents are retained.
REQ-026 Bit and sample counters SHALL be sized to $clog2 of their range and never wrap within a frame.

Reset
REQ-027 On rst_n low: state=IDLE, counters=0, shift register=0, rx_byte=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0, sync flops=1.
REQ-028 Reset asserted mid-frame SHALL discard the frame; after release the receiver waits for a fresh falling edge.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: one even-parity bit follows the data bits; it is sampled in state PARITY and checked against the XOR of data bits.
REQ-030 UART_RX_PARITY_EN undefined: no PARITY state, the frame has no parity bit, and parity_err is tied to 0.

Verification (CLKS_PER_BIT=16, DATA_WIDTH=8)
REQ-031 Frame 0x47 sent, rx_ready=1 -> rx_byte=0x47, one rx_valid cycle, no flags.
REQ-032 Low glitch of 4 cycles on an idle line -> no rx_valid, FSM back in IDLE, no flags.
REQ-033 Frame 0x33 sent with the stop bit driven low, then the line held low for 40 cycles, then frame 0x55 -> frame_err once, only 0x55 delivered.
REQ-034 Frames 0xA5 then 0x5A sent with rx_ready=0 -> rx_byte=0xA5, overrun once; raise rx_ready -> 0xA5 consumed, rx_valid=0.
REQ-035 rx_en dropped during bit 3 of 0xFF, and separately rst_n pulsed during bit 5 -> no load, no flags, next frame 0x12 received correctly.
REQ-036 With UART_RX_PARITY_EN: frame 0x07 with parity bit 0 -> parity_err pulse and rx_byte=0x07; with parity bit 1 -> no error.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: serial-to-parallel UART receiver with a one-entry valid/ready output buffer.
// Latency: the byte appears on the cycle after the stop-bit sample. A frame takes about (DATA_WIDTH+2) bit periods.
// Backpressure: holds one unconsumed byte. A frame that completes while the buffer is full and not draining is dropped and raises overrun.
// Ports: clk, rst_n (async, active-low), rx_en, ftdi_rx (async serial in, idle high),
//        rx_byte/rx_valid/rx_ready (output handshake), frame_err/overrun/parity_err (1-cycle pulses).
// Optional: define UART_RX_PARITY_EN to add one even-parity bit after the data bits.
module uart_rx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_en,
  input  logic                  ftdi_rx,
  output logic [DATA_WIDTH-1:0] rx_byte,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  parity_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_bit;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  rx_s1, rx_s2, rx_d;
  // Set after a low stop bit: stay in STOP until the line returns high so a
  // held-low line cannot be mistaken for a new start bit.
  logic                  stop_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_d      <= 1'b1;
      stop_wait <= 1'b0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_s1     <= ftdi_rx;
      rx_s2     <= rx_s1;
      rx_d      <= rx_s2;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // Handshake drains the buffer; a same-cycle good frame reloads it below.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (!rx_en) begin
        state     <= IDLE;
        cnt       <= '0;
        bit_cnt   <= '0;
        stop_wait <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_d && !rx_s2) begin
              state   <= START;
              cnt     <= '0;
              bit_cnt <= '0;
            end
          end
          START: begin
            if (cnt == HALF_CNT) begin
              cnt   <= '0;
              state <= rx_s2 ? IDLE : DATA;   // high at mid-start = glitch
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == LAST_CNT) begin
              cnt   <= '0;
              shreg <= DATA_WIDTH'({rx_s2, shreg} >> 1);  // LSB arrives first
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (cnt == LAST_CNT) begin
              cnt     <= '0;
              par_bit <= rx_s2;
              state   <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (stop_wait) begin
              if (rx_s2) begin
                stop_wait <= 1'b0;
                state     <= IDLE;
              end
            end else if (cnt == LAST_CNT) begin
              cnt <= '0;
              if (!rx_s2) begin
                frame_err <= 1'b1;
                stop_wait <= 1'b1;
              end else begin
                state <= IDLE;
                if (rx_valid && !rx_ready) begin
                  overrun <= 1'b1;
                end else begin
                  rx_byte  <= shreg;
                  rx_valid <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                parity_err <= (^shreg) ^ par_bit;
`endif
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_en = 1'b0;
  logic       ftdi_rx = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err, overrun, parity_err;

  int vectors = 0;
  int miscompares = 0;

  // Event counters, written only by the monitor; tests compare deltas.
  int         hs_cnt = 0, vcyc_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
  logic [7:0] last_byte = 8'h00;

  uart_rx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .ftdi_rx(ftdi_rx),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) vcyc_cnt++;
      if (rx_valid && rx_ready) begin
        hs_cnt++;
        last_byte = rx_byte;
      end
      if (frame_err)  ferr_cnt++;
      if (overrun)    ovr_cnt++;
      if (parity_err) perr_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic line(input logic v, input int n);
    ftdi_rx = v;
    tick(n);
  endtask

  // Full frame: start, 8 data bits LSB first, [parity], stop, then 2 idle bits.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    line(par_v, CPB);
`else
    if (par_v) begin end
`endif
    line(stop_v, CPB);
    if (stop_v) line(1'b1, 2 * CPB);
  endtask

  task automatic test_reset;
    tick(3);
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    vectors++; if (rx_byte !== 8'h00) begin miscompares++; $display("FAIL reset_rx_byte got=%h exp=00", rx_byte); end
    vectors++; if ({frame_err, overrun, parity_err} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got=%b exp=000", {frame_err, overrun, parity_err}); end
    rst_n = 1'b1;
    rx_en = 1'b1;
    tick(5);
  endtask

  task automatic test_basic;
    int h0, v0, f0, o0;
    h0 = hs_cnt; v0 = vcyc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    rx_ready = 1'b1;
    send_frame(8'h47, 1'b1, ^8'h47);
    vectors++; if (hs_cnt - h0 !== 1) begin miscompares++; $display("FAIL basic_handshakes got=%0d exp=1", hs_cnt - h0); end
    vectors++; if (vcyc_cnt - v0 !== 1) begin miscompares++; $display("FAIL basic_valid_cycles got=%0d exp=1", vcyc_cnt - v0); end
    vectors++; if (last_byte !== 8'h47) begin miscompares++; $display("FAIL basic_byte got=%h exp=47", last_byte); end
    vectors++; if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin miscompares++; $display("FAIL basic_flags got=%0d exp=0", (ferr_cnt - f0) + (ovr_cnt - o0)); end
  endtask

  task automatic test_glitch;
    int v0, f0, o0;
    v0 = vcyc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    line(1'b0, 4);
    line(1'b1, 3 * CPB);
    vectors++; if (vcyc_cnt - v0 !== 0) begin miscompares++; $display("FAIL glitch_valid got=%0d exp=0", vcyc_cnt - v0); end
    vectors++; if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin miscompares++; $display("FAIL glitch_flags got=%0d exp=0", (ferr_cnt - f0) + (ovr_cnt - o0)); end
    // Receiver must be back in IDLE: an immediate frame is received.
    send_frame(8'hC3, 1'b1, ^8'hC3);
    vectors++; if (last_byte !== 8'hC3) begin miscompares++; $display("FAIL glitch_recover got=%h exp=c3", last_byte); end
  endtask

  task automatic test_frame_err;
    int h0, f0;
    h0 = hs_cnt; f0 = ferr_cnt;
    send_frame(8'h33, 1'b0, ^8'h33);
    line(1'b0, 40);
    line(1'b1, 2 * CPB);
    send_frame(8'h55, 1'b1, ^8'h55);
    vectors++; if (ferr_cnt - f0 !== 1) begin miscompares++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
    vectors++; if (hs_cnt - h0 !== 1) begin miscompares++; $display("FAIL ferr_delivered got=%0d exp=1", hs_cnt - h0); end
    vectors++; if (last_byte !== 8'h55) begin miscompares++; $display("FAIL ferr_byte got=%h exp=55", last_byte); end
  endtask

  task automatic test_overrun;
    int h0, o0;
    h0 = hs_cnt; o0 = ovr_cnt;
    rx_ready = 1'b0;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    vectors++; if (ovr_cnt - o0 !== 1) begin miscompares++; $display("FAIL ovr_count got=%0d exp=1", ovr_cnt - o0); end
    vectors++; if (rx_byte !== 8'hA5) begin miscompares++; $display("FAIL ovr_kept_byte got=%h exp=a5", rx_byte); end
    vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid_held got=%b exp=1", rx_valid); end
    rx_ready = 1'b1;
    tick(3);
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_drained got=%b exp=0", rx_valid); end
    vectors++; if (hs_cnt - h0 !== 1 || last_byte !== 8'hA5) begin miscompares++; $display("FAIL ovr_consumed got=%0d/%h exp=1/a5", hs_cnt - h0, last_byte); end
  endtask

  task automatic test_abort;
    int v0, f0, o0;
    v0 = vcyc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    // rx_en dropped mid bit 3 of 0xFF.
    line(1'b0, CPB);
    line(1'b1, 3 * CPB + CPB / 2);
    rx_en = 1'b0;
    tick(2);
    rx_en = 1'b1;
    line(1'b1, CPB / 2 - 2 + 5 * CPB + 3 * CPB);
    vectors++; if (vcyc_cnt - v0 !== 0) begin miscompares++; $display("FAIL en_abort_valid got=%0d exp=0", vcyc_cnt - v0); end
    // rst_n pulsed mid bit 5 of 0xFF.
    line(1'b0, CPB);
    line(1'b1, 5 * CPB + CPB / 2);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    line(1'b1, CPB / 2 - 3 + 3 * CPB + 3 * CPB);
    vectors++; if (vcyc_cnt - v0 !== 0) begin miscompares++; $display("FAIL rst_abort_valid got=%0d exp=0", vcyc_cnt - v0); end
    vectors++; if ((ferr_cnt - f0) + (ovr_cnt - o0) !== 0) begin miscompares++; $display("FAIL abort_flags got=%0d exp=0", (ferr_cnt - f0) + (ovr_cnt - o0)); end
    send_frame(8'h12, 1'b1, ^8'h12);
    vectors++; if (vcyc_cnt - v0 !== 1 || last_byte !== 8'h12) begin miscompares++; $display("FAIL abort_next_frame got=%0d/%h exp=1/12", vcyc_cnt - v0, last_byte); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int p0;
    p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    vectors++; if (perr_cnt - p0 !== 1) begin miscompares++; $display("FAIL parity_bad_pulse got=%0d exp=1", perr_cnt - p0); end
    vectors++; if (last_byte !== 8'h07) begin miscompares++; $display("FAIL parity_bad_byte got=%h exp=07", last_byte); end
    p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    vectors++; if (perr_cnt - p0 !== 0) begin miscompares++; $display("FAIL parity_good_pulse got=%0d exp=0", perr_cnt - p0); end
  endtask
`else
  task automatic test_parity;
    int p0;
    p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    vectors++; if (perr_cnt - p0 !== 0) begin miscompares++; $display("FAIL parity_tied_low got=%0d exp=0", perr_cnt - p0); end
    vectors++; if (last_byte !== 8'h07) begin miscompares++; $display("FAIL noparity_byte got=%h exp=07", last_byte); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_abort;
    test_parity;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
